// File: rtl/gcn_mem_fetch.sv
// Read initiator for the GCN memory and COO ports: loads weight columns, streams
// feature rows to the compute stage, then captures the COO edge list.
module gcn_mem_fetch #(
  parameter int FEATURE_COLS    = 96,
  parameter int WEIGHT_ROWS     = 96,
  parameter int FEATURE_ROWS    = 6,
  parameter int WEIGHT_COLS     = 3,
  parameter int FEATURE_WIDTH   = 5,
  parameter int WEIGHT_WIDTH    = 5,
  parameter int ADDRESS_WIDTH   = 13,
  parameter int FEATURE_BASE    = 512,
  parameter int COO_NUM_OF_COLS = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  localparam int FIDX_W         = $clog2(FEATURE_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WEIGHT_WIDTH-1:0]  data_in [0:WEIGHT_ROWS-1],
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     enable_read,
  input  logic [2*COO_BW-1:0]      coo_in,
  output logic [COO_BW-1:0]        coo_address,
  output logic [WEIGHT_WIDTH-1:0]  weight_buf [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1],
  output logic [FEATURE_WIDTH-1:0] fm_row [0:FEATURE_COLS-1],
  output logic [FIDX_W-1:0]        fm_row_idx,
  output logic                     fm_valid,
  input  logic                     fm_ready,
  output logic [COO_BW-1:0]        coo_src [0:COO_NUM_OF_COLS-1],
  output logic [COO_BW-1:0]        coo_dst [0:COO_NUM_OF_COLS-1],
  output logic                     done,
  output logic [2:0]               fsm_state
);

  localparam int WIDX_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_W   = 3'd1,
    S_LOAD_F   = 3'd2,
    S_HOLD_F   = 3'd3,
    S_LOAD_COO = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   w_idx_q, w_idx_d;
  logic [FIDX_W-1:0]   f_idx_q, f_idx_d;
  logic [COO_BW-1:0]   c_idx_q, c_idx_d;

  logic [WEIGHT_WIDTH-1:0]  weight_buf_q [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
  logic [FEATURE_WIDTH-1:0] fm_row_q [0:FEATURE_COLS-1];
  logic [FIDX_W-1:0]        fm_row_idx_q;
  logic                     fm_valid_q;
  logic [COO_BW-1:0]        coo_src_q [0:COO_NUM_OF_COLS-1];
  logic [COO_BW-1:0]        coo_dst_q [0:COO_NUM_OF_COLS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      w_idx_q <= '0;
      f_idx_q <= '0;
      c_idx_q <= '0;
    end else begin
      state_q <= state_d;
      w_idx_q <= w_idx_d;
      f_idx_q <= f_idx_d;
      c_idx_q <= c_idx_d;
    end
  end

  // Handshake: fm_valid rises with a captured row and stays high, with fm_row and
  // fm_row_idx frozen, until a rising edge in HOLD_F samples fm_ready high.
  always_comb begin
    state_d = state_q;
    w_idx_d = w_idx_q;
    f_idx_d = f_idx_q;
    c_idx_d = c_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          w_idx_d = '0;
        end
      end
      S_LOAD_W: begin
        if (w_idx_q == WIDX_W'(WEIGHT_COLS-1)) begin
          state_d = S_LOAD_F;
          f_idx_d = '0;
        end else begin
          w_idx_d = w_idx_q + 1'b1;
        end
      end
      S_LOAD_F: state_d = S_HOLD_F;
      S_HOLD_F: begin
        if (fm_ready) begin
          if (f_idx_q == FIDX_W'(FEATURE_ROWS-1)) begin
            state_d = S_LOAD_COO;
            c_idx_d = '0;
          end else begin
            f_idx_d = f_idx_q + 1'b1;
            state_d = S_LOAD_F;
          end
        end
      end
      S_LOAD_COO: begin
        if (c_idx_q == COO_BW'(COO_NUM_OF_COLS-1)) begin
          state_d = S_DONE;
        end else begin
          c_idx_d = c_idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port strobes decode from registered state only, so no input reaches them.
  always_comb begin
    enable_read  = 1'b0;
    read_address = '0;
    coo_address  = '0;
    done         = 1'b0;
    unique case (state_q)
      S_LOAD_W: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(w_idx_q);
      end
      S_LOAD_F: begin
        enable_read  = 1'b1;
        read_address = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(f_idx_q);
      end
      S_LOAD_COO: coo_address = c_idx_q;
      S_DONE:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      weight_buf_q <= '{default: '0};
      fm_row_q     <= '{default: '0};
      fm_row_idx_q <= '0;
      fm_valid_q   <= 1'b0;
      coo_src_q    <= '{default: '0};
      coo_dst_q    <= '{default: '0};
    end else begin
      unique case (state_q)
        S_LOAD_W: begin
          for (int k = 0; k < WEIGHT_ROWS; k++) weight_buf_q[w_idx_q][k] <= data_in[k];
        end
        S_LOAD_F: begin
          for (int k = 0; k < FEATURE_COLS; k++) fm_row_q[k] <= FEATURE_WIDTH'(data_in[k]);
          fm_row_idx_q <= f_idx_q;
          fm_valid_q   <= 1'b1;
        end
        S_HOLD_F: begin
          if (fm_ready) fm_valid_q <= 1'b0;
        end
        S_LOAD_COO: begin
          coo_src_q[c_idx_q] <= coo_in[2*COO_BW-1:COO_BW];
          coo_dst_q[c_idx_q] <= coo_in[COO_BW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign weight_buf = weight_buf_q;
  assign fm_row     = fm_row_q;
  assign fm_row_idx = fm_row_idx_q;
  assign fm_valid   = fm_valid_q;
  assign coo_src    = coo_src_q;
  assign coo_dst    = coo_dst_q;
  assign fsm_state  = state_q;

endmodule

// File: doc/gcn_mem_fetch.md
Name: gcn_mem_fetch

Overview:
- Read-initiator for the GCN external memory and COO ports: drives read_address/enable_read and coo_address, and captures the combinational responses.
- Loads all weight columns into an internal buffer, then streams feature rows one at a time to the compute stage over a valid/ready handshake, then captures the COO edge list.
- Asserts done when the fetch sequence completes. Sits between the top-level GCN ports and the transformation/aggregation datapath.

Parameters:
FEATURE_COLS, 96, elements per feature row
WEIGHT_ROWS, 96, elements per weight column (equals FEATURE_COLS)
FEATURE_ROWS, 6, number of feature rows (nodes)
WEIGHT_COLS, 3, number of weight columns
FEATURE_WIDTH, 5, feature element width
WEIGHT_WIDTH, 5, weight element width
ADDRESS_WIDTH, 13, memory read address width
FEATURE_BASE, 512, address of feature row 0; weight column c is at address c
COO_NUM_OF_COLS, 6, number of COO edges
COO_BW, $clog2(COO_NUM_OF_COLS), COO index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level; begins the fetch sequence when sampled high in IDLE
data_in  in  [WEIGHT_WIDTH-1:0] x [0:WEIGHT_ROWS-1]  memory read data, valid in the same cycle as the address
read_address  out  ADDRESS_WIDTH  memory read address
enable_read  out  1  memory read strobe
coo_in  in  2*COO_BW  {src, dst} for coo_address; src is the upper half
coo_address  out  COO_BW  COO column index
weight_buf  out  [WEIGHT_WIDTH-1:0] x [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1]  captured weights
fm_row  out  [FEATURE_WIDTH-1:0] x [0:FEATURE_COLS-1]  current feature row
fm_row_idx  out  $clog2(FEATURE_ROWS)  index of fm_row
fm_valid  out  1  fm_row and fm_row_idx are valid
fm_ready  in  1  consumer accepts the row
coo_src  out  [COO_BW-1:0] x [0:COO_NUM_OF_COLS-1]  captured source indices
coo_dst  out  [COO_BW-1:0] x [0:COO_NUM_OF_COLS-1]  captured destination indices
done  out  1  sticky completion flag

Behaviour:
- Reset: state IDLE. All counters, weight_buf, fm_row, coo_src, coo_dst, fm_row_idx, fm_valid, done, read_address, enable_read and coo_address are 0. Reset overrides everything, including mid-sequence; no partial data survives.
- read_address, enable_read and coo_address are decoded from the registered state and counters only. No path from any input to these outputs. read_address = 0 whenever enable_read = 0.
- data_in and coo_in are captured at the rising edge ending the cycle in which the address is presented. There is no extra read latency.
- IDLE: start=1 at an edge -> LOAD_W with w_idx=0. Otherwise remain in IDLE.
- LOAD_W: enable_read=1, read_address=w_idx. Each edge, weight_buf[w_idx] <= data_in. If w_idx == WEIGHT_COLS-1, go to LOAD_F with f_idx=0; otherwise w_idx++. Lasts exactly WEIGHT_COLS cycles.
- LOAD_F: enable_read=1, read_address=FEATURE_BASE+f_idx. At the edge: fm_row <= data_in, fm_row_idx <= f_idx, fm_valid <= 1, go to HOLD_F.
- HOLD_F: enable_read=0. fm_row and fm_row_idx are held stable. fm_ready is sampled only in this state; an fm_ready that is already high on entry is accepted at the first HOLD_F edge.
  - On an edge with fm_ready=1: fm_valid <= 0.
  - If f_idx == FEATURE_ROWS-1, go to LOAD_COO with c_idx=0. Otherwise f_idx++ and go to LOAD_F.
  - If fm_ready=0, stay indefinitely. No timeout.
- LOAD_COO: coo_address=c_idx. Each edge: coo_src[c_idx] <= coo_in[2*COO_BW-1:COO_BW], coo_dst[c_idx] <= coo_in[COO_BW-1:0]. If c_idx == COO_NUM_OF_COLS-1, go to DONE; otherwise c_idx++.
- DONE: done=1, sticky. Buffers are held and start is ignored. Only reset leaves DONE.
- coo_address = 0 outside LOAD_COO.
- With fm_ready tied high, cycle counts from edge E0 (start sampled in IDLE):
  - weights captured at E1–E3
  - feature row r captured at E(4+2r) and accepted at E(5+2r)
  - COO captured at E16–E21
  - done=1 after E21
  - Total 21 cycles after E0. Each fm_ready-low cycle adds one cycle.
- Address width: FEATURE_BASE+f_idx is computed at ADDRESS_WIDTH bits and must not overflow for the default parameters.

Test Plan:
- Nominal: memory model returns weight column c as all-(c+1) and feature row r as all-(r+8); coo src={0,0,1,2,3,4}, dst={1,2,3,4,5,5}; fm_ready=1 -> addresses 0,1,2,512,513…517 in order; weight_buf[2][k]=3; fm_row_idx 0..5 each with fm_row = r+8; coo_src/coo_dst match; done rises exactly 21 cycles after start is sampled.
- Backpressure: hold fm_ready=0 for 4 cycles on row 2 -> fm_valid, fm_row and fm_row_idx=2 stable; enable_read=0; no read of 515 until acceptance; done 4 cycles later (25).
- Reset mid-stream: assert reset during HOLD_F of row 3 -> next edge: all outputs 0 and IDLE. Restart -> full sequence from address 0 with correct data.
- Start held low, then pulsed for one cycle -> no reads while low; a single-cycle start completes the full sequence.
- Post-done: keep start=1 and toggle fm_ready after done -> no further enable_read or coo_address activity; done and buffers unchanged.
- Protocol checks throughout: read_address=0 whenever enable_read=0; coo_address=0 outside the COO phase; fm_valid never drops without fm_ready.
